// File: rtl/cyq_sw_pkg.sv
// rtl/cyq_sw_pkg.sv - shared types and constants for the stopwatch core
package cyq_sw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_e;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] DIG_MAX_LO = 4'd9;
  localparam logic [BCD_W-1:0] DIG_MAX_HI = 4'd5;
  localparam logic [3:0] DP_MASK = 4'b0100;

  // {carry, next digit}; anything at or above dmax wraps so a digit never leaves BCD range
  function automatic logic [BCD_W:0] bcd_inc(input logic [BCD_W-1:0] d,
                                             input logic [BCD_W-1:0] dmax);
    if (d >= dmax) return {1'b1, {BCD_W{1'b0}}};
    return {1'b0, d + 1'b1};
  endfunction

endpackage

// File: rtl/cyq_debounce.sv
// rtl/cyq_debounce.sv - 2-FF synchronizer, stable-sample debouncer, rising-edge pulse
module cyq_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt tracks how many consecutive synchronized samples disagree with the current level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
          pulse <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cyq_stopwatch_core.sv
// rtl/cyq_stopwatch_core.sv - SS.hh stopwatch: button debounce, run/pause/lap FSM, BCD count
module cyq_stopwatch_core
  import cyq_sw_pkg::*;
#(
  parameter int TICK_DIV   = 500000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic        Clk,
  input  logic        Aclr,
  input  logic        Btn_StartStop,
  input  logic        Btn_Lap,
  input  logic        Btn_Clear,
  output logic [15:0] Digits,
  output logic [3:0]  Dp_En,
  output logic        Running,
  output logic        Lap_Active
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic ss_p, lap_p, clr_p;

  cyq_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss  (.clk(Clk), .rst(Aclr), .din(Btn_StartStop), .pulse(ss_p));
  cyq_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (.clk(Clk), .rst(Aclr), .din(Btn_Lap),       .pulse(lap_p));
  cyq_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (.clk(Clk), .rst(Aclr), .din(Btn_Clear),     .pulse(clr_p));

  sw_state_e     state, state_nx;
  logic          capture, clear;
  logic [PW-1:0] presc;
  logic          counting, tick;
  logic [15:0]   cnt_q, cnt_nx, lap_q;
  logic [BCD_W:0] inc0, inc1, inc2;

  // Highest-priority pulse wins; lower ones in the same cycle are simply dropped
  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    clear    = 1'b0;
    if (clr_p) begin
      if (state == ST_PAUSE) begin
        state_nx = ST_IDLE;
        clear    = 1'b1;
      end
    end else if (ss_p) begin
      case (state)
        ST_IDLE:  state_nx = ST_RUN;
        ST_RUN:   state_nx = ST_PAUSE;
        ST_PAUSE: state_nx = ST_RUN;
        ST_LAP:   state_nx = ST_PAUSE;
        default:  state_nx = ST_IDLE;
      endcase
    end else if (lap_p) begin
      if (state == ST_RUN || state == ST_LAP) begin
        state_nx = ST_LAP;
        capture  = 1'b1;
      end
    end
  end

  assign counting = (state == ST_RUN) || (state == ST_LAP);
  assign tick     = counting && (presc == PRESC_LAST);

  always_comb begin
    inc0   = bcd_inc(cnt_q[3:0],  DIG_MAX_LO);
    inc1   = bcd_inc(cnt_q[7:4],  DIG_MAX_LO);
    inc2   = bcd_inc(cnt_q[11:8], DIG_MAX_LO);
    cnt_nx = cnt_q;
    cnt_nx[3:0] = inc0[BCD_W-1:0];
    if (inc0[BCD_W]) begin
      cnt_nx[7:4] = inc1[BCD_W-1:0];
      if (inc1[BCD_W]) begin
        cnt_nx[11:8] = inc2[BCD_W-1:0];
        if (inc2[BCD_W]) begin
          cnt_nx[15:12] = (cnt_q[15:12] >= DIG_MAX_HI) ? '0 : cnt_q[15:12] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Aclr) begin
      state      <= ST_IDLE;
      presc      <= '0;
      cnt_q      <= '0;
      lap_q      <= '0;
      Running    <= 1'b0;
      Lap_Active <= 1'b0;
    end else begin
      state      <= state_nx;
      Running    <= (state_nx == ST_RUN) || (state_nx == ST_LAP);
      Lap_Active <= (state_nx == ST_LAP);

      // PAUSE falls through both branches, so the prescaler keeps its partial count
      if (counting) begin
        presc <= tick ? '0 : presc + 1'b1;
      end else if (state == ST_IDLE || clear) begin
        presc <= '0;
      end

      if (clear) begin
        cnt_q <= '0;
      end else if (tick) begin
        cnt_q <= cnt_nx;
      end

      if (clear) begin
        lap_q <= '0;
      end else if (capture) begin
        lap_q <= cnt_q;
      end
    end
  end

  assign Digits = Lap_Active ? lap_q : cnt_q;
  assign Dp_En  = DP_MASK;

endmodule

// File: tb/tb_cyq_stopwatch_core.sv
// tb/tb_cyq_stopwatch_core.sv - randomized bench against an elapsed-time reference model
module tb_cyq_stopwatch_core;

  localparam int TD = 4;
  localparam int DB = 3;

  logic        Clk = 1'b0;
  logic        Aclr = 1'b1;
  logic        b_ss = 1'b0, b_lap = 1'b0, b_clr = 1'b0;
  logic [15:0] Digits;
  logic [3:0]  Dp_En;
  logic        Running, Lap_Active;

  cyq_stopwatch_core #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
    .Clk(Clk), .Aclr(Aclr),
    .Btn_StartStop(b_ss), .Btn_Lap(b_lap), .Btn_Clear(b_clr),
    .Digits(Digits), .Dp_En(Dp_En), .Running(Running), .Lap_Active(Lap_Active)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 run, 2 pause, 3 lap; time is total counting cycles since last clear
  int m_st, m_run, m_lap;
  bit m_lvl[3], m_pls[3], m_r1[3], m_r2[3];
  int m_since[3];
  bit m_hist[3][DB];

  function automatic logic [15:0] to_bcd(input int v);
    logic [3:0] a, b, c, d;
    a = 4'(v / 1000);
    b = 4'((v / 100) % 10);
    c = 4'((v / 10) % 10);
    d = 4'(v % 10);
    return {a, b, c, d};
  endfunction

  task automatic model_reset();
    m_st = 0; m_run = 0; m_lap = 0;
    for (int b = 0; b < 3; b++) begin
      m_lvl[b] = 0; m_pls[b] = 0; m_r1[b] = 0; m_r2[b] = 0; m_since[b] = 0;
      for (int i = 0; i < DB; i++) m_hist[b][i] = 0;
    end
  endtask

  task automatic model_edge(input bit rst, input bit r0, input bit r1, input bit r2);
    int  old_st;
    bit  raw[3];
    bit  s, all_opp;
    if (rst) begin
      model_reset();
      return;
    end
    raw[0] = r0; raw[1] = r1; raw[2] = r2;
    old_st = m_st;
    if (m_pls[2]) begin
      if (m_st == 2) begin m_st = 0; m_run = 0; m_lap = 0; end
    end else if (m_pls[0]) begin
      case (m_st)
        0: m_st = 1;
        1: m_st = 2;
        2: m_st = 1;
        default: m_st = 2;
      endcase
    end else if (m_pls[1]) begin
      if (m_st == 1 || m_st == 3) begin
        m_lap = (m_run / TD) % 6000;
        m_st  = 3;
      end
    end
    if (old_st == 1 || old_st == 3) m_run++;
    for (int b = 0; b < 3; b++) begin
      s = m_r2[b];
      m_r2[b] = m_r1[b];
      m_r1[b] = raw[b];
      for (int i = 0; i < DB - 1; i++) m_hist[b][i] = m_hist[b][i+1];
      m_hist[b][DB-1] = s;
      m_since[b]++;
      all_opp = 1;
      for (int i = 0; i < DB; i++) if (m_hist[b][i] == m_lvl[b]) all_opp = 0;
      if (m_since[b] >= DB && all_opp) begin
        m_lvl[b]   = ~m_lvl[b];
        m_pls[b]   = m_lvl[b];
        m_since[b] = 0;
      end else begin
        m_pls[b] = 0;
      end
    end
  endtask

  task automatic cycle();
    logic [15:0] exp_d;
    @(posedge Clk);
    model_edge(Aclr, b_ss, b_lap, b_clr);
    @(negedge Clk);
    exp_d = (m_st == 3) ? to_bcd(m_lap) : to_bcd((m_run / TD) % 6000);
    check_val("digits", Digits, exp_d);
    check_val("running", Running, (m_st == 1 || m_st == 3));
    check_val("lap_active", Lap_Active, (m_st == 3));
    check_val("dp_en", Dp_En, 4'b0100);
  endtask

  task automatic press_ss(input int n);
    b_ss = 1'b1;
    repeat (n) cycle();
    b_ss = 1'b0;
  endtask

  initial begin
    int sel, hold, gap, guard;
    model_reset();
    Aclr = 1'b1;
    repeat (2) begin
      b_ss = 1'($urandom); b_lap = 1'($urandom); b_clr = 1'($urandom);
      cycle();
    end
    b_ss = 0; b_lap = 0; b_clr = 0;
    check_val("rst_digits", Digits, 16'h0000);
    check_val("rst_running", Running, 1'b0);
    check_val("rst_lap", Lap_Active, 1'b0);
    check_val("rst_dp", Dp_En, 4'b0100);
    Aclr = 1'b0;

    // Bouncing start button, then settled high
    for (int i = 0; i < 10; i++) begin
      b_ss = (i % 2 == 0);
      cycle();
    end
    press_ss(8);
    check_val("deb_run", Running, 1'b1);

    for (int ep = 0; ep < 80; ep++) begin
      if ($urandom_range(0, 29) == 0) begin
        Aclr = 1'b1;
        repeat ($urandom_range(1, 2)) cycle();
        Aclr = 1'b0;
      end
      sel  = $urandom_range(0, 9);
      hold = $urandom_range(1, 8);
      for (int h = 0; h < hold; h++) begin
        b_ss  = (sel <= 3 || sel == 9) && ($urandom_range(0, 4) != 0);
        b_lap = (sel >= 4 && sel <= 6) && ($urandom_range(0, 4) != 0);
        b_clr = (sel == 7 || sel == 8 || sel == 9) && ($urandom_range(0, 4) != 0);
        cycle();
      end
      b_ss = 0; b_lap = 0; b_clr = 0;
      gap = $urandom_range(4, 30);
      repeat (gap) cycle();
    end

    // Run all the way to 59.99 and across the wrap
    Aclr = 1'b1; cycle(); Aclr = 1'b0;
    press_ss(6);
    guard = 0;
    while (!(m_st == 1 && ((m_run / TD) % 6000) == 5999) && guard < 30000) begin
      cycle();
      guard++;
    end
    check_val("wrap_reach", (guard < 30000), 1'b1);
    check_val("pre_wrap", Digits, 16'h5999);
    repeat (4) cycle();
    check_val("post_wrap", Digits, 16'h0000);
    check_val("post_wrap_run", Running, 1'b1);

    // Pause, then Clear and StartStop together: Clear must win
    press_ss(6);
    repeat (4) cycle();
    check_val("paused", Running, 1'b0);
    b_clr = 1'b1;
    press_ss(6);
    b_clr = 1'b0;
    repeat (4) cycle();
    check_val("prio_digits", Digits, 16'h0000);
    check_val("prio_idle", Running, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cyq_stopwatch_core.md
# cyq_stopwatch_core

Stopwatch counting core that generates the four BCD digits shown on the 4-digit seven-segment display driver (cyq_SSD2), which sits directly downstream and multiplexes COM_1..COM_4 and segments a–g. It debounces three push-buttons, runs a run/pause/lap state machine, and counts seconds and hundredths in the SS.hh format, from 00.00 to 59.99 with wrap. It also provides a decimal-point enable for the display stage.

## Interface
Parameters:
- TICK_DIV, 500000: Clk cycles per 0.01 s tick (50 MHz). Legal minimum is 2.
- DEB_CYCLES, 1000000: consecutive stable samples required before a debounced button changes. Legal minimum is 1.

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- Aclr  in  1  synchronous, active-high reset.
- Btn_StartStop  in  1  raw button, active-high, asynchronous to Clk.
- Btn_Lap  in  1  raw button, active-high, asynchronous.
- Btn_Clear  in  1  raw button, active-high, asynchronous.
- Digits  out  16  BCD display value {S_tens, S_ones, H_tens, H_ones}, with [15:12] as the leftmost digit.
- Dp_En  out  4  one-hot decimal-point enable; constant 4'b0100 (point after S_ones).
- Running  out  1  high in the RUN and LAP states.
- Lap_Active  out  1  high in the LAP state.

## Operation
- Button path: each button goes through a 2-FF synchronizer and then a debouncer. The debounced level changes only after DEB_CYCLES consecutive identical synchronized samples. A 1-cycle pulse fires on the debounced rising edge; a falling edge does nothing.
- Prescaler: counts 0..TICK_DIV-1 in RUN and LAP. It holds its value in PAUSE and is forced to 0 in IDLE. It emits a 1-cycle tick when the count reaches TICK_DIV-1, then wraps to 0.
- Counter: four BCD digits with ripple carry, clocked by the tick.
  - H_ones wraps 9→0 and carries into H_tens.
  - H_tens wraps 9→0 and carries into S_ones.
  - S_ones wraps 9→0 and carries into S_tens.
  - S_tens wraps 5→0. 59.99 → 00.00 on the next tick and keeps running; there is no overflow flag.
  - No digit ever holds a non-BCD value.
- FSM states:
  - IDLE: count is 0.
  - RUN
  - PAUSE
  - LAP: counting continues and the display is frozen.
- FSM transitions, evaluated on debounced pulses:
  - IDLE –StartStop→ RUN.
  - RUN –StartStop→ PAUSE.
  - RUN –Lap→ LAP, capturing the count into the lap register.
  - LAP –Lap→ LAP, re-capturing the current count.
  - LAP –StartStop→ PAUSE. Display unfreezes and shows the live count.
  - PAUSE –StartStop→ RUN.
  - PAUSE –Clear→ IDLE.
  - Clear in RUN or LAP is ignored. Lap in IDLE or PAUSE is ignored.
- Pulse priority in the same cycle: Clear > StartStop > Lap. The lower-priority pulse is dropped, not queued.
- Digits output: equals the lap register in LAP; equals the live count in every other state.

## Timing
- Reset (Aclr high at an edge):
  - FSM goes to IDLE; count, lap register and prescaler go to 0.
  - Debouncer levels and synchronizers go to 0.
  - Outputs: Digits=16'h0000, Running=0, Lap_Active=0, Dp_En=4'b0100.
  - Reset dominates all other inputs. Reset mid-count discards the count.
- Button-to-pulse latency: 2 sync cycles + DEB_CYCLES, so the pulse is visible DEB_CYCLES+2 edges after the raw input rises.
- State update: the FSM state changes on the edge after the debounced pulse. Running and Lap_Active are registered, so they follow the state with no extra delay.
- Count update: tick is high in cycle N; the count changes at edge N+1. Digits (live) changes in that same cycle, because it is a registered count driven through a mux.
- First tick after IDLE→RUN arrives TICK_DIV cycles after entering RUN.
- PAUSE→RUN resumes the prescaler from its held value, so no partial tick is lost.
- Lap capture takes the count value present at the edge where the state changes; it does not include a tick occurring in that same cycle.

## Structure
- Shared package cyq_sw_pkg:
  - FSM state enum (IDLE, RUN, PAUSE, LAP).
  - BCD digit width constant (4).
  - Digit max constants (9, 5).
  - DP mask constant 4'b0100.
- Sub-module cyq_debounce: synchronizer, stable-counter and rising-edge pulse, parameterized by DEB_CYCLES. It is instantiated three times.
- Prescaler, BCD counter, FSM and lap register are implemented inline.

## Test plan
All scenarios use TICK_DIV=4 and DEB_CYCLES=3.
- Reset: Aclr held 2 cycles with buttons bouncing → Digits=0000, Running=0, Lap_Active=0, Dp_En=0100.
- Debounce: StartStop toggles 1/0 every cycle for 10 cycles, then settles at 1 → exactly one RUN entry, 5 cycles after settling. Glitches shorter than 3 cycles give no pulse.
- Count and wrap: count preloaded by running 5999 ticks → Digits=5999. After 4 more cycles, Digits=0000 and Running=1.
- Lap: press Lap at count 0012 → Digits stays 0012 while the live count advances. Lap again at live 0020 → shows 0020. StartStop → PAUSE, with the live count displayed.
- Pause and resume: pause 2 cycles after a tick, wait 50 cycles → count unchanged. Resume → next tick after 2 more cycles, not 4.
- Priority: Clear and StartStop pulse together in PAUSE → IDLE, Digits=0000. Clear in RUN → ignored and the count continues.
